// File: rtl/pool_window_gen.sv
// 2x2 non-overlapping window former for the mean-pooling stage: one pixel per beat in, one packed window out.
// Optional frame resync on an in_sof marker is enabled with `define POOL_SOF_RESYNC_EN.
module pool_window_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                clock,
   input  logic                reset,
`ifdef POOL_SOF_RESYNC_EN
   input  logic                in_sof,
   output logic                sof_err,
`endif
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [4*DATA_W-1:0] nh_vector,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last
);

   localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  eff_col;
   logic [ROW_W-1:0]  eff_row;
   logic [DATA_W-1:0] hold;
   logic [DATA_W-1:0] line_buf [IMG_W];
   logic              accept;
   logic              restart;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

`ifdef POOL_SOF_RESYNC_EN
   assign restart = in_sof;
`else
   assign restart = 1'b0;
`endif

   // A start-of-frame beat is handled as pixel (0,0) regardless of where the counters were.
   assign eff_col = restart ? '0 : col;
   assign eff_row = restart ? '0 : row;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (eff_col == COL_LAST) begin
            col <= '0;
            row <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
         end else begin
            col <= eff_col + COL_W'(1);
            row <= eff_row;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept && !eff_row[0])
         line_buf[eff_col] <= in_data;
   end

   // On an odd row the even-column pixel waits in hold until its right-hand neighbour arrives.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold      <= '0;
         nh_vector <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (accept && eff_row[0] && !eff_col[0])
            hold <= in_data;
         if (accept && eff_row[0] && eff_col[0]) begin
            nh_vector <= {in_data, hold, line_buf[eff_col], line_buf[eff_col - COL_W'(1)]};
            out_valid <= 1'b1;
            out_last  <= (eff_row == ROW_LAST) && (eff_col == COL_LAST);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef POOL_SOF_RESYNC_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         sof_err <= 1'b0;
      else
         sof_err <= accept && in_sof && ((col != '0) || (row != '0));
   end
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen on a 4x4 map; pixel values equal their raster index so each
// window is predicted from its bottom-right value alone.
module tb_pool_window_gen;

   typedef struct packed {
      logic [31:0] vec;
      logic        last;
   } win_t;

   logic        clock;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] nh_vector;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        in_sof;
`ifdef POOL_SOF_RESYNC_EN
   logic        sof_err;
   int          sof_pulses;
`endif

   win_t exp_q[$];
   int   tests;
   int   fails;
   int   win_count;
   int   last_count;

   pool_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
      .clock     (clock),
      .reset     (reset),
`ifdef POOL_SOF_RESYNC_EN
      .in_sof    (in_sof),
      .sof_err   (sof_err),
`endif
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .nh_vector (nh_vector),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic win_t window_for(input logic [7:0] v);
      win_t w;
      w.vec  = {v, v - 8'd1, v - 8'd4, v - 8'd5};
      w.last = (v == 8'd15);
      return w;
   endfunction

   // Scoreboard: every consumed window is popped and compared against the prediction queue.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL window_unexpected got=%h last=%b expected none", nh_vector, out_last);
         end else begin
            win_t e;
            e = exp_q.pop_front();
            if (nh_vector !== e.vec || out_last !== e.last) begin
               fails++;
               $display("[TB] FAIL window got=%h last=%b expected=%h last=%b",
                        nh_vector, out_last, e.vec, e.last);
            end
         end
         win_count++;
         if (out_last) last_count++;
      end
`ifdef POOL_SOF_RESYNC_EN
      if (reset && sof_err === 1'b1) sof_pulses++;
`endif
   end

   // Offers one pixel until it is accepted; entered and left one time unit after a rising edge.
   task automatic send_pixel(input logic [7:0] v, input logic sof, input int valid_pct, input int ready_pct);
      logic done;
      int   guard;
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
         in_valid  = ($urandom_range(99) < valid_pct);
         in_data   = v;
         in_sof    = sof;
         out_ready = ($urandom_range(99) < ready_pct);
         @(negedge clock);
         if (in_valid && in_ready) begin
            done = 1'b1;
            if (v[2] && v[0]) exp_q.push_back(window_for(v));
         end
         @(posedge clock);
         #1;
         guard++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("[TB] FAIL accept_timeout pixel=%0d got no acceptance expected acceptance", v);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #3;
      tests += 4;
      if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got=%b expected=0", out_valid); end
      if (out_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_last got=%b expected=0", out_last); end
      if (nh_vector !== 32'h0) begin fails++; $display("[TB] FAIL reset_nh_vector got=%h expected=0", nh_vector); end
      if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got=%b expected=1", in_ready); end
`ifdef POOL_SOF_RESYNC_EN
      tests++;
      if (sof_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_sof_err got=%b expected=0", sof_err); end
`endif
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_single_frame();
      win_count  = 0;
      last_count = 0;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] v;
         v = 8'(i);
         send_pixel(v, 1'b0, 100, 100);
         tests++;
         if (out_valid !== (v[2] & v[0])) begin
            fails++;
            $display("[TB] FAIL latency pixel=%0d out_valid got=%b expected=%b", v, out_valid, v[2] & v[0]);
         end
      end
      drain();
      tests += 2;
      if (win_count !== 4) begin fails++; $display("[TB] FAIL single_count got=%0d expected=4", win_count); end
      if (last_count !== 1) begin fails++; $display("[TB] FAIL single_last got=%0d expected=1", last_count); end
   endtask

   task automatic test_back_to_back();
      win_count  = 0;
      last_count = 0;
      for (int i = 0; i < 32; i++) send_pixel(8'(i % 16), 1'b0, 100, 100);
      drain();
      tests += 3;
      if (win_count !== 8) begin fails++; $display("[TB] FAIL b2b_count got=%0d expected=8", win_count); end
      if (last_count !== 2) begin fails++; $display("[TB] FAIL b2b_last got=%0d expected=2", last_count); end
      if (exp_q.size() !== 0) begin fails++; $display("[TB] FAIL b2b_leftover got=%0d expected=0", exp_q.size()); end
   endtask

   task automatic test_stall();
      win_count  = 0;
      last_count = 0;
      for (int i = 0; i < 6; i++) send_pixel(8'(i), 1'b0, 100, 100);
      for (int c = 0; c < 5; c++) begin
         in_valid  = 1'b1;
         in_data   = 8'd6;
         out_ready = 1'b0;
         @(negedge clock);
         tests += 3;
         if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_in_ready cycle=%0d got=%b expected=0", c, in_ready); end
         if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_out_valid cycle=%0d got=%b expected=1", c, out_valid); end
         if (nh_vector !== 32'h05040100) begin
            fails++;
            $display("[TB] FAIL stall_hold cycle=%0d got=%h expected=05040100", c, nh_vector);
         end
         @(posedge clock);
         #1;
      end
      for (int i = 6; i < 16; i++) send_pixel(8'(i), 1'b0, 100, 100);
      drain();
      tests += 2;
      if (win_count !== 4) begin fails++; $display("[TB] FAIL stall_count got=%0d expected=4", win_count); end
      if (exp_q.size() !== 0) begin fails++; $display("[TB] FAIL stall_leftover got=%0d expected=0", exp_q.size()); end
   endtask

   task automatic test_random_gaps();
      win_count  = 0;
      last_count = 0;
      for (int i = 0; i < 16; i++) send_pixel(8'(i), 1'b0, 50, 50);
      drain();
      tests += 3;
      if (win_count !== 4) begin fails++; $display("[TB] FAIL random_count got=%0d expected=4", win_count); end
      if (last_count !== 1) begin fails++; $display("[TB] FAIL random_last got=%0d expected=1", last_count); end
      if (exp_q.size() !== 0) begin fails++; $display("[TB] FAIL random_leftover got=%0d expected=0", exp_q.size()); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) send_pixel(8'(i), 1'b0, 100, 100);
      send_pixel(8'd5, 1'b0, 100, 0);
      in_valid  = 1'b1;
      in_data   = 8'd6;
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL pre_reset_valid got=%b expected=1", out_valid); end
      #2;
      reset = 1'b0;
      #1;
      tests += 3;
      if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_out_valid got=%b expected=0", out_valid); end
      if (nh_vector !== 32'h0) begin fails++; $display("[TB] FAIL midreset_nh_vector got=%h expected=0", nh_vector); end
      if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreset_in_ready got=%b expected=1", in_ready); end
      exp_q.delete();
      in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      win_count  = 0;
      last_count = 0;
      for (int i = 0; i < 16; i++) send_pixel(8'(i), 1'b0, 100, 100);
      drain();
      tests += 2;
      if (win_count !== 4) begin fails++; $display("[TB] FAIL midreset_count got=%0d expected=4", win_count); end
      if (last_count !== 1) begin fails++; $display("[TB] FAIL midreset_last got=%0d expected=1", last_count); end
   endtask

`ifdef POOL_SOF_RESYNC_EN
   task automatic test_sof_resync();
      win_count  = 0;
      last_count = 0;
      sof_pulses = 0;
      for (int i = 0; i < 6; i++) send_pixel(8'(i), 1'b0, 100, 100);
      for (int i = 0; i < 16; i++) send_pixel(8'(i), (i == 0), 100, 100);
      drain();
      tests += 4;
      if (sof_pulses !== 1) begin fails++; $display("[TB] FAIL sof_err_pulses got=%0d expected=1", sof_pulses); end
      if (win_count !== 5) begin fails++; $display("[TB] FAIL sof_count got=%0d expected=5", win_count); end
      if (last_count !== 1) begin fails++; $display("[TB] FAIL sof_last got=%0d expected=1", last_count); end
      if (exp_q.size() !== 0) begin fails++; $display("[TB] FAIL sof_leftover got=%0d expected=0", exp_q.size()); end
   endtask
`endif

   initial begin
      tests     = 0;
      fails     = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      in_sof    = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_stall();
      test_random_gaps();
      test_mid_reset();
`ifdef POOL_SOF_RESYNC_EN
      test_sof_resync();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
